// File: rtl/logic_serializer_if.sv
// Operand/result bus for the bit-serial logic sequencer. The master side is
// whoever supplies operands and hosts the 1-bit logicunit. The slave side is
// the serializer itself.
interface logic_serializer_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [1:0]       control;
   logic             lu_a;
   logic             lu_b;
   logic [1:0]       lu_control;
   logic             lu_out;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, A, B, control, lu_out,
      input  lu_a, lu_b, lu_control, busy, done, result
   );

   modport slave (
      input  start, A, B, control, lu_out,
      output lu_a, lu_b, lu_control, busy, done, result
   );
endinterface

// File: rtl/logic_serializer.sv
// Bit-serial operand sequencer around a 1-bit logicunit.
// Presents one operand bit pair per cycle, LSB first, for WIDTH cycles. It
// collects the returned bit into an accumulator and publishes the full-width
// result with a one-cycle done pulse.
module logic_serializer #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   logic_serializer_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] aShift;
   logic [WIDTH-1:0] bShift;
   logic [1:0]       ctrlHold;
   logic [WIDTH-2:0] acc;
   logic [WIDTH-1:0] accNext;
   logic [CW-1:0]    bitCount;
   logic [WIDTH-1:0] resultReg;
   logic             accept;
   logic             lastBit;

   assign accept  = (state == IDLE) && bus.start;
   assign lastBit = (state == SHIFT) && (bitCount == LAST_BIT);

   // The accumulator keeps only the upper WIDTH-1 bits of the shifting
   // window. The lowest bit of the next value falls straight into the result
   // on the final edge and is never needed afterwards.
   assign accNext = {bus.lu_out, acc};

   // Sequencer: IDLE waits for start, SHIFT runs WIDTH cycles, DONE is the
   // single cycle during which done is high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (bus.start) state <= SHIFT;
            SHIFT:   if (bitCount == LAST_BIT) state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Operand shift registers: loaded on acceptance, then shifted right once
   // per SHIFT edge so bit 0 is always the pair being evaluated. They drain
   // to zero by the end of an operation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         aShift <= '0;
         bShift <= '0;
      end else if (accept) begin
         aShift <= bus.A;
         bShift <= bus.B;
      end else if (state == SHIFT) begin
         aShift <= aShift >> 1;
         bShift <= bShift >> 1;
      end
   end

   // Control is held for the logicunit from acceptance until the next
   // acceptance, so lu_control stays stable in IDLE and DONE as well.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrlHold <= 2'b00;
      end else if (accept) begin
         ctrlHold <= bus.control;
      end
   end

   // Bit counter: cleared on acceptance, counts SHIFT edges, and returns to
   // zero on the final edge instead of wrapping past WIDTH-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bitCount <= '0;
      end else if (accept || lastBit) begin
         bitCount <= '0;
      end else if (state == SHIFT) begin
         bitCount <= bitCount + CW'(1);
      end
   end

   // Accumulator: each returned bit enters at the MSB, so after WIDTH edges
   // the first (LSB) result bit has walked down to bit 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else if (accept) begin
         acc <= '0;
      end else if (state == SHIFT) begin
         acc <= accNext[WIDTH-1:1];
      end
   end

   // Published result: updated only on the final SHIFT edge, including that
   // edge's returned bit, and held until the next completion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resultReg <= '0;
      end else if (lastBit) begin
         resultReg <= accNext;
      end
   end

   assign bus.lu_a       = aShift[0];
   assign bus.lu_b       = bShift[0];
   assign bus.lu_control = ctrlHold;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);
   assign bus.result     = resultReg;

endmodule

// File: tb/tb_logic_serializer.sv
// Self-checking bench for logic_serializer at WIDTH=8. A stand-in 1-bit
// logicunit sits on the lu_* pins. Expected results come from whole-word
// bitwise operations on the operands.
module tb_logic_serializer;

   localparam int W = 8;

   logic clk;
   logic reset_n;

   int assertCount = 0;
   int failCount   = 0;
   logic [W-1:0] lastResult = '0;

   logic_serializer_if #(.WIDTH(W)) bus ();

   logic_serializer #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream 1-bit logic cell: combinational result for the current pair.
   always_comb begin
      bus.lu_out = 1'b0;
      case (bus.lu_control)
         2'd0: bus.lu_out = bus.lu_a & bus.lu_b;
         2'd1: bus.lu_out = bus.lu_a | bus.lu_b;
         2'd2: bus.lu_out = ~(bus.lu_a | bus.lu_b);
         2'd3: bus.lu_out = bus.lu_a ^ bus.lu_b;
         default: bus.lu_out = 1'b0;
      endcase
   end

   // Watchdog so the run always ends even if the DUT stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Whole-word reference for the four operations.
   function automatic logic [W-1:0] refOp(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] c);
      case (c)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return ~(a | b);
         default: return a ^ b;
      endcase
   endfunction

   // Compare observed and expected values and record the outcome.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present an operation request. It is accepted at the next edge if idle.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] c);
      bus.start   = 1'b1;
      bus.A       = a;
      bus.B       = b;
      bus.control = c;
   endtask

   // Run one operation from idle. Check per-cycle bit presentation, latency,
   // result, held value and the single-cycle done pulse.
   task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] c,
                        input string tag);
      logic [W-1:0] exp;
      int cyc;
      exp = refOp(a, b, c);
      applyStimulus(a, b, c);
      @(posedge clk); #1;
      bus.start = 1'b0;
      checkOutput({tag, " busy"}, 32'(bus.busy), 32'd1);
      cyc = 0;
      while (!bus.done && cyc < 20) begin
         if (cyc < W) begin
            checkOutput({tag, " lu_a"}, 32'(bus.lu_a), 32'(a[cyc]));
            checkOutput({tag, " lu_b"}, 32'(bus.lu_b), 32'(b[cyc]));
         end
         if (cyc == 4) checkOutput({tag, " held"}, 32'(bus.result), 32'(lastResult));
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput({tag, " latency"}, 32'(cyc), 32'(W));
      checkOutput({tag, " result"}, 32'(bus.result), 32'(exp));
      checkOutput({tag, " lu_control"}, 32'(bus.lu_control), 32'(c));
      lastResult = exp;
      @(posedge clk); #1;
      checkOutput({tag, " done width"}, 32'(bus.done), 32'd0);
      checkOutput({tag, " idle"}, 32'(bus.busy), 32'd0);
      checkOutput({tag, " result kept"}, 32'(bus.result), 32'(exp));
   endtask

   initial begin
      logic [W-1:0] qa [$];
      logic [W-1:0] qb [$];
      logic [1:0]   qc [$];
      logic [W-1:0] expQ [$];
      int doneCount;
      int pushed;
      int lastDone;
      logic [W-1:0] ra, rb, expRes;
      logic [1:0]   rc;

      reset_n     = 1'b0;
      bus.start   = 1'b0;
      bus.A       = '0;
      bus.B       = '0;
      bus.control = 2'd0;

      // Power-up reset values.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("por busy", 32'(bus.busy), 32'd0);
      checkOutput("por done", 32'(bus.done), 32'd0);
      checkOutput("por result", 32'(bus.result), 32'd0);
      checkOutput("por lu_control", 32'(bus.lu_control), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // All four operations on the same operands.
      runOp(8'hCA, 8'h5C, 2'd0, "and");
      checkOutput("and const", 32'(bus.result), 32'h48);
      runOp(8'hCA, 8'h5C, 2'd1, "or");
      checkOutput("or const", 32'(bus.result), 32'hDE);
      runOp(8'hCA, 8'h5C, 2'd2, "nor");
      checkOutput("nor const", 32'(bus.result), 32'h21);
      runOp(8'hCA, 8'h5C, 2'd3, "xor");
      checkOutput("xor const", 32'(bus.result), 32'h96);

      // Reset pulse between edges clears outputs without a clock edge.
      #2 reset_n = 1'b0;
      #1;
      checkOutput("pulse busy", 32'(bus.busy), 32'd0);
      checkOutput("pulse done", 32'(bus.done), 32'd0);
      checkOutput("pulse result", 32'(bus.result), 32'd0);
      checkOutput("pulse lu_control", 32'(bus.lu_control), 32'd0);
      #1 reset_n = 1'b1;
      lastResult = '0;
      @(posedge clk); #1;

      // Bit order: only the first SHIFT cycle carries a set A bit.
      runOp(8'h01, 8'h00, 2'd1, "bitorder");
      checkOutput("bitorder const", 32'(bus.result), 32'h01);

      // Busy protection: a start pulse with new operands mid-SHIFT is ignored.
      applyStimulus(8'hFF, 8'h0F, 2'd3);
      @(posedge clk); #1;
      bus.start = 1'b0;
      doneCount = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         if (cyc == 2) applyStimulus(8'h00, 8'h00, 2'd0);
         if (cyc == 3) bus.start = 1'b0;
         @(posedge clk); #1;
         if (bus.done) begin
            doneCount++;
            checkOutput("busyprot result", 32'(bus.result), 32'hF0);
         end
      end
      checkOutput("busyprot done count", 32'(doneCount), 32'd1);
      checkOutput("busyprot idle", 32'(bus.busy), 32'd0);
      checkOutput("busyprot kept", 32'(bus.result), 32'hF0);
      lastResult = 8'hF0;

      // Randomized single operations.
      for (int i = 0; i < 16; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 2'($urandom_range(0, 3));
         runOp(ra, rb, rc, "random");
      end

      // Back-to-back with start held high: one accept every W+2 cycles.
      for (int i = 0; i < 6; i++) begin
         qa.push_back(W'($urandom));
         qb.push_back(W'($urandom));
         qc.push_back(2'($urandom_range(0, 3)));
      end
      pushed = 1;
      applyStimulus(qa[0], qb[0], qc[0]);
      expQ.push_back(refOp(qa[0], qb[0], qc[0]));
      doneCount = 0;
      lastDone  = -1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            expRes = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            checkOutput("b2b result", 32'(bus.result), 32'(expRes));
            if (lastDone >= 0) checkOutput("b2b spacing", 32'(cyc - lastDone), 32'(W + 2));
            lastDone = cyc;
            doneCount++;
            if (pushed < 6) begin
               applyStimulus(qa[pushed], qb[pushed], qc[pushed]);
               expQ.push_back(refOp(qa[pushed], qb[pushed], qc[pushed]));
               pushed++;
            end else begin
               bus.start = 1'b0;
               lastResult = expRes;
            end
         end
      end
      checkOutput("b2b done count", 32'(doneCount), 32'd6);
      checkOutput("b2b leftover", 32'(expQ.size()), 32'd0);
      bus.start = 1'b0;

      // Mid-operation reset in the 4th SHIFT cycle aborts without done.
      applyStimulus(8'hFF, 8'h0F, 2'd3);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      #2 reset_n = 1'b0;
      #1;
      checkOutput("abort busy", 32'(bus.busy), 32'd0);
      checkOutput("abort result", 32'(bus.result), 32'd0);
      checkOutput("abort done", 32'(bus.done), 32'd0);
      checkOutput("abort lu_control", 32'(bus.lu_control), 32'd0);
      @(posedge clk); #1;
      checkOutput("abort no done", 32'(bus.done), 32'd0);
      reset_n = 1'b1;
      lastResult = '0;
      @(posedge clk); #1;
      checkOutput("abort still idle", 32'(bus.done | bus.busy), 32'd0);
      runOp(8'hCA, 8'h5C, 2'd0, "after abort");
      checkOutput("after abort const", 32'(bus.result), 32'h48);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/logic_serializer.md
# logic_serializer

Bit-serial operand sequencer that sits around the 1-bit `logicunit`. It accepts two WIDTH-bit operands and a 2-bit operation, then feeds one bit pair per cycle, LSB first, into the downstream `logicunit`. Each cycle it captures the returned output bit and assembles the WIDTH-bit result. This lets a single 1-bit logic cell evaluate full-width AND/OR/NOR/XOR without replicating the cell.

## Interface
- `WIDTH`, default 8: operand/result width; legal range 2..32.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request to begin an operation; sampled only when idle.
- `A`  in  WIDTH: first operand; latched on acceptance.
- `B`  in  WIDTH: second operand; latched on acceptance.
- `control`  in  2: operation select, passed unchanged to `logicunit` (0 AND, 1 OR, 2 NOR, 3 XOR); latched on acceptance.
- `lu_a`  out  1: current A bit to `logicunit`.
- `lu_b`  out  1: current B bit to `logicunit`.
- `lu_control`  out  2: latched control to `logicunit`.
- `lu_out`  in  1: combinational result bit from `logicunit`.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse when `result` has just been updated.
- `result`  out  WIDTH: last completed result; held until the next completion.

## Operation
- States:
  - IDLE: `start`=1 at an edge latches A, B and control into internal shift/hold registers, clears the bit counter, and moves to SHIFT. `start`=0 stays in IDLE.
  - SHIFT: lasts exactly WIDTH cycles.
    - `lu_a`/`lu_b` are bit 0 of the A/B shift registers.
    - Each edge shifts A and B right by one.
    - Each edge shifts `lu_out` into the MSB of the internal accumulate register (`acc <= {lu_out, acc[WIDTH-1:1]}`).
    - Each edge increments the counter.
    - On the edge where counter = WIDTH-1, `result` is loaded with the final accumulate value (including that edge's `lu_out`) and the state moves to DONE.
  - DONE: `done`=1 for this one cycle. Next edge returns to IDLE unconditionally.
- `start` is ignored while `busy`=1; it is not queued.
- Operand/control inputs are don't-care except at the accepting edge.
- `lu_control` always reflects the latched control, including in IDLE and DONE.
- `lu_a`/`lu_b` outside SHIFT are the residual shift-register bit 0 (0 after reset or after a completed operation). The bench does not check them outside SHIFT.
- Bit i of `result` = `logicunit`(A[i], B[i], control). The bit order is fixed, LSB first.
- Counter width: clog2(WIDTH); no wrap beyond WIDTH-1.
- No arithmetic beyond the counter; result width equals WIDTH, with no extension.

## Timing
- Reset (`reset_n`=0, asynchronous assert, synchronous-safe deassert):
  - state IDLE, `busy`=0, `done`=0, `result`=0.
  - `lu_a`=`lu_b`=0, `lu_control`=0.
  - All internal registers are 0.
- Accepting edge = E0. SHIFT occupies the cycles after E0 through E0+WIDTH; bit i is presented in the cycle after edge E0+i.
- `result` updates and `done` rises after edge E0+WIDTH; `done` falls after E0+WIDTH+1.
- Start-to-done latency: WIDTH edges. Occupancy: WIDTH+1 cycles.
- Earliest next accept: edge E0+WIDTH+2. With `start` held high, throughput is one operation per WIDTH+2 cycles.
- `lu_out` is sampled at the same edge that shifts its inputs away. The path `lu_a`/`lu_b` → `logicunit` → `lu_out` is single-cycle combinational.
- Reset asserted mid-SHIFT or in DONE aborts immediately:
  - `result` clears to 0.
  - No `done` pulse.
  - The next accepted `start` behaves as from power-up.
- `start`=1 in the same cycle `reset_n` deasserts is sampled normally at the first edge with `reset_n`=1.

## Test plan
Bench: WIDTH=8, `logicunit` instantiated as the downstream stage on `lu_*`.

1. **Reset values.** Pulse `reset_n` low between edges. Required: `busy`=0, `done`=0, `result`=8'h00, `lu_control`=0, all immediately and without a clock edge.
2. **All four operations.** A=8'hCA, B=8'h5C; run control=0/1/2/3 in sequence. Required: `result` = 8'h48 / 8'hDE / 8'h21 / 8'h96 respectively. Each `done` arrives exactly 8 edges after acceptance, lasts one cycle, and `result` holds its value between completions.
3. **Bit order.** A=8'h01, B=8'h00, control=1. Required: `lu_a`=1 only in the first SHIFT cycle; `result`=8'h01.
4. **Busy protection.** Accept A=8'hFF, B=8'h0F, control=3. On the 3rd SHIFT cycle, pulse `start` and change A/B/control. Required: the pulse is ignored, `result`=8'hF0, and `done` pulses once.
5. **Back-to-back.** Hold `start`=1 continuously with varying operands. Required: accepts occur every 10 cycles, and no operation is dropped or duplicated.
6. **Mid-operation reset.** Drop `reset_n` during the 4th SHIFT cycle. Required: `busy`=0 and `result`=8'h00 immediately, with no `done`. A subsequent A=8'hCA, B=8'h5C, control=0 then yields 8'h48.
